positadd_4_raw: RTL and testbench

POSITADD_4_RAW -- requirements
Module: positadd_4_raw

---
 rtl/positadd_4_raw.sv | 235 +++++++++++++++++++++++
 tb/tb_positadd_4_raw.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/positadd_4_raw.sv
// positadd_4_raw: 4-stage pipelined adder for raw (unpacked) posit<32,2> operands.
//   clk        rising-edge clock
//   reset      asynchronous active-high clear of all pipeline registers
//   in1, in2   raw operands: [37] sign, [36:29] scale, [28:2] fraction, [1] inf, [0] zero
//   start      operands valid this cycle
//   result     raw sum: [41] sign, [40:33] scale, [32:2] fraction, [1] inf, [0] zero
//   done       start delayed by four clocks
//   truncated  nonzero bits (including sticky) lie below result[2]; no rounding here
module positadd_4_raw (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] in1,
  input  logic [37:0] in2,
  input  logic        start,
  output logic [41:0] result,
  output logic        done,
  output logic        truncated
);

  localparam int unsigned FW   = 27;  // operand fraction bits
  localparam int unsigned SCW  = 8;   // scale bits
  localparam int unsigned MW   = 32;  // hidden + fraction + 4 guard bits
  localparam int unsigned EW   = 33;  // mantissa plus sticky slot
  localparam int unsigned SUMW = 34;  // sum with carry-out
  localparam int unsigned RFW  = 31;  // result fraction bits

  // Stage 1: classify, order by magnitude, scale difference
  logic           s1_vld_d,   s1_vld_q;
  logic           s1_inf_d,   s1_inf_q;
  logic           s1_zero_d,  s1_zero_q;
  logic           s1_szero_d, s1_szero_q;
  logic           s1_sign_d,  s1_sign_q;
  logic           s1_sub_d,   s1_sub_q;
  logic [SCW-1:0] s1_scale_d, s1_scale_q;
  logic [FW-1:0]  s1_fl_d,    s1_fl_q;
  logic [FW-1:0]  s1_fs_d,    s1_fs_q;
  logic [8:0]     s1_diff_d,  s1_diff_q;

  logic [37:0] big, sml;
  logic        a_ge;

  always_comb begin
    // Flipping the scale sign bit makes {scale, fraction} compare as unsigned.
    a_ge = {~in1[36], in1[35:2]} >= {~in2[36], in2[35:2]};
    big  = in1;
    sml  = in2;
    // A zero operand is always treated as the smaller one.
    if (in1[0] || (!in2[0] && !a_ge)) begin
      big = in2;
      sml = in1;
    end
    s1_vld_d   = start;
    s1_inf_d   = in1[1] | in2[1];
    s1_zero_d  = in1[0] & in2[0];
    s1_szero_d = in1[0] | in2[0];
    s1_sign_d  = big[37];
    s1_sub_d   = (big[37] ^ sml[37]) & ~s1_szero_d;
    s1_scale_d = big[36:29];
    s1_fl_d    = big[28:2];
    s1_fs_d    = sml[28:2];
    // Difference is 0..255, so 9-bit modular arithmetic is exact.
    s1_diff_d  = {big[36], big[36:29]} - {sml[36], sml[36:29]};
  end

  // Stage 2: align smaller mantissa, collect sticky
  logic           s2_vld_d,    s2_vld_q;
  logic           s2_inf_d,    s2_inf_q;
  logic           s2_zero_d,   s2_zero_q;
  logic           s2_sign_d,   s2_sign_q;
  logic           s2_sub_d,    s2_sub_q;
  logic           s2_sticky_d, s2_sticky_q;
  logic [SCW-1:0] s2_scale_d,  s2_scale_q;
  logic [EW-1:0]  s2_ext_l_d,  s2_ext_l_q;
  logic [EW-1:0]  s2_ext_s_d,  s2_ext_s_q;

  logic [MW-1:0] m_s, sh_s;

  always_comb begin
    m_s         = {1'b1, s1_fs_q, 4'b0000};
    sh_s        = '0;
    s2_sticky_d = 1'b0;
    if (s1_szero_q) begin
      sh_s        = '0;
      s2_sticky_d = 1'b0;
    end else if (s1_diff_q >= 9'(MW)) begin
      sh_s        = '0;
      s2_sticky_d = 1'b1;
    end else begin
      sh_s        = m_s >> s1_diff_q[4:0];
      s2_sticky_d = |(m_s & ((32'd1 << s1_diff_q[4:0]) - 32'd1));
    end
    s2_vld_d   = s1_vld_q;
    s2_inf_d   = s1_inf_q;
    s2_zero_d  = s1_zero_q;
    s2_sign_d  = s1_sign_q;
    s2_sub_d   = s1_sub_q;
    s2_scale_d = s1_scale_q;
    s2_ext_l_d = {1'b1, s1_fl_q, 4'b0000, 1'b0};
    // Sticky takes part in the arithmetic as the lowest bit.
    s2_ext_s_d = {sh_s, s2_sticky_d};
  end

  // Stage 3: magnitude add or subtract (larger minus smaller)
  logic            s3_vld_d,    s3_vld_q;
  logic            s3_inf_d,    s3_inf_q;
  logic            s3_zero_d,   s3_zero_q;
  logic            s3_sign_d,   s3_sign_q;
  logic            s3_sticky_d, s3_sticky_q;
  logic [SCW-1:0]  s3_scale_d,  s3_scale_q;
  logic [SUMW-1:0] s3_sum_d,    s3_sum_q;

  always_comb begin
    s3_vld_d    = s2_vld_q;
    s3_inf_d    = s2_inf_q;
    s3_zero_d   = s2_zero_q;
    s3_sign_d   = s2_sign_q;
    s3_sticky_d = s2_sticky_q;
    s3_scale_d  = s2_scale_q;
    if (s2_sub_q) s3_sum_d = {1'b0, s2_ext_l_q} - {1'b0, s2_ext_s_q};
    else          s3_sum_d = {1'b0, s2_ext_l_q} + {1'b0, s2_ext_s_q};
  end

  // Stage 4: normalize, saturate scale, pack
  logic            done_d,      done_q;
  logic            truncated_d, truncated_q;
  logic [41:0]     result_d,    result_q;

  logic [5:0]        lz;
  logic [EW-1:0]     shifted;
  logic [RFW-1:0]    frac;
  logic              below;
  logic signed [9:0] sc;
  logic [SCW-1:0]    sc_sat;

  always_comb begin
    lz = 6'd33;
    for (int i = 0; i < 33; i++) begin
      if (s3_sum_q[i]) lz = 6'(32 - i);
    end
    shifted = s3_sum_q[EW-1:0] << lz;
    if (s3_sum_q[SUMW-1]) begin
      frac  = s3_sum_q[32:2];
      below = |s3_sum_q[1:0];
      sc    = $signed({{2{s3_scale_q[7]}}, s3_scale_q}) + 10'sd1;
    end else begin
      frac  = shifted[31:1];
      below = shifted[0];
      sc    = $signed({{2{s3_scale_q[7]}}, s3_scale_q}) - $signed({4'b0000, lz});
    end
    if (sc < -10'sd128)     sc_sat = 8'h80;
    else if (sc > 10'sd127) sc_sat = 8'h7f;
    else                    sc_sat = sc[7:0];

    done_d      = s3_vld_q;
    result_d    = {s3_sign_q, sc_sat, frac, 2'b00};
    truncated_d = below | s3_sticky_q;
    if (s3_inf_q) begin
      result_d    = 42'h2;
      truncated_d = 1'b0;
    end else if (s3_zero_q || (s3_sum_q == '0)) begin
      result_d    = 42'h1;
      truncated_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_szero_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_scale_q  <= '0;
      s1_fl_q     <= '0;
      s1_fs_q     <= '0;
      s1_diff_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_sub_q    <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_scale_q  <= '0;
      s2_ext_l_q  <= '0;
      s2_ext_s_q  <= '0;
      s3_vld_q    <= 1'b0;
      s3_inf_q    <= 1'b0;
      s3_zero_q   <= 1'b0;
      s3_sign_q   <= 1'b0;
      s3_sticky_q <= 1'b0;
      s3_scale_q  <= '0;
      s3_sum_q    <= '0;
      done_q      <= 1'b0;
      truncated_q <= 1'b0;
      result_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_inf_q    <= s1_inf_d;
      s1_zero_q   <= s1_zero_d;
      s1_szero_q  <= s1_szero_d;
      s1_sign_q   <= s1_sign_d;
      s1_sub_q    <= s1_sub_d;
      s1_scale_q  <= s1_scale_d;
      s1_fl_q     <= s1_fl_d;
      s1_fs_q     <= s1_fs_d;
      s1_diff_q   <= s1_diff_d;
      s2_vld_q    <= s2_vld_d;
      s2_inf_q    <= s2_inf_d;
      s2_zero_q   <= s2_zero_d;
      s2_sign_q   <= s2_sign_d;
      s2_sub_q    <= s2_sub_d;
      s2_sticky_q <= s2_sticky_d;
      s2_scale_q  <= s2_scale_d;
      s2_ext_l_q  <= s2_ext_l_d;
      s2_ext_s_q  <= s2_ext_s_d;
      s3_vld_q    <= s3_vld_d;
      s3_inf_q    <= s3_inf_d;
      s3_zero_q   <= s3_zero_d;
      s3_sign_q   <= s3_sign_d;
      s3_sticky_q <= s3_sticky_d;
      s3_scale_q  <= s3_scale_d;
      s3_sum_q    <= s3_sum_d;
      done_q      <= done_d;
      truncated_q <= truncated_d;
      result_q    <= result_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_positadd_4_raw.sv
// tb_positadd_4_raw: directed vector table plus random back-to-back stream for positadd_4_raw,
// checked through a scoreboard of expected {truncated, result} and a start-history for done.
module tb_positadd_4_raw;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] in1, in2;
  logic        start;
  logic [41:0] result;
  logic        done;
  logic        truncated;

  always #5 clk = ~clk;

  positadd_4_raw dut (
    .clk       (clk),
    .reset     (reset),
    .in1       (in1),
    .in2       (in2),
    .start     (start),
    .result    (result),
    .done      (done),
    .truncated (truncated)
  );

  typedef struct {
    logic [37:0] a;
    logic [37:0] b;
    logic [42:0] exp;  // {truncated, result}
  } vec_t;

  vec_t        vecs[16];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [42:0] sb[$];
  logic        hist[$];

  function automatic logic [37:0] op(input logic s, input logic [7:0] sc, input logic [26:0] f,
                                     input logic inf, input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [42:0] ex(input logic t, input logic s, input logic [7:0] sc,
                                     input logic [30:0] f, input logic inf, input logic z);
    return {t, s, sc, f, inf, z};
  endfunction

  function automatic logic [42:0] pass_thru(input logic [37:0] x);
    return {1'b0, x[37], x[36:29], x[28:2], 4'b0000, 2'b00};
  endfunction

  // Reference: wide-integer align/add with the leading one located by position.
  function automatic logic [42:0] model(input logic [37:0] a, input logic [37:0] b);
    logic [37:0] bg, sm;
    int          sa, sb_s, d, p, sc;
    logic [63:0] mb, ms, sh, s;
    logic        st, tr;
    logic [30:0] fr;
    if (a[1] || b[1]) return 43'h2;
    if (a[0] && b[0]) return 43'h1;
    if (a[0]) return pass_thru(b);
    if (b[0]) return pass_thru(a);
    sa   = int'($signed(a[36:29]));
    sb_s = int'($signed(b[36:29]));
    if (sa > sb_s || (sa == sb_s && a[28:2] >= b[28:2])) begin
      bg = a; sm = b;
    end else begin
      bg = b; sm = a;
    end
    d  = int'($signed(bg[36:29])) - int'($signed(sm[36:29]));
    mb = {31'b0, 1'b1, bg[28:2], 4'b0000, 1'b0};
    ms = {32'b0, 1'b1, sm[28:2], 4'b0000};
    if (d >= 32) begin
      sh = 64'd0; st = 1'b1;
    end else begin
      sh = ms >> d; st = ((sh << d) != ms);
    end
    if (bg[37] != sm[37]) s = mb - ((sh << 1) | 64'(st));
    else                  s = mb + ((sh << 1) | 64'(st));
    if (s == 64'd0) return 43'h1;
    p = 0;
    for (int i = 0; i < 40; i++) if (s[i]) p = i;
    if (p >= 32) begin
      fr = 31'(s >> (p - 31));
      tr = ((s & ((64'd1 << (p - 31)) - 64'd1)) != 64'd0);
    end else begin
      fr = 31'(s << (31 - p));
      tr = 1'b0;
    end
    tr = tr | st;
    sc = int'($signed(bg[36:29])) + p - 32;
    if (sc < -128) sc = -128;
    if (sc > 127)  sc = 127;
    return {tr, bg[37], 8'(sc), fr, 2'b00};
  endfunction

  function automatic logic [37:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 27'($urandom),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
  endfunction

  // Second operand often near the first so cancellation paths get exercised.
  function automatic logic [37:0] rnd_near(input logic [37:0] a);
    logic [37:0] b;
    b = rnd_op();
    if ($urandom_range(0, 1) == 1) b[36:29] = a[36:29] + 8'($urandom_range(0, 6)) - 8'd3;
    if ($urandom_range(0, 5) == 0) begin
      b[28:2] = a[28:2];
      b[37]   = ~a[37];
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  task automatic check_out();
    logic        exp_done;
    logic [42:0] e;
    exp_done = 1'b0;
    if (hist.size() >= 4) exp_done = hist.pop_front();
    chk("done", 64'(done), 64'(exp_done));
    if (exp_done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard: expected entry missing");
      end else begin
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e[41:0]));
        chk("truncated", 64'(truncated), 64'(e[42]));
      end
    end
  endtask

  task automatic cycle(input logic st, input logic [37:0] a, input logic [37:0] b,
                       input logic [42:0] e);
    @(negedge clk);
    check_out();
    start = st;
    in1   = a;
    in2   = b;
    hist.push_back(st);
    if (st) sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [37:0] a, b;
    vecs[0]  = '{op(0, 8'd0, 0, 0, 0), op(0, 8'd0, 0, 0, 0), ex(0, 0, 8'd1, 0, 0, 0)};
    vecs[1]  = '{op(0, 8'd0, 27'h4000000, 0, 0), op(0, 8'hFE, 0, 0, 0),
                 ex(0, 0, 8'd0, 31'h60000000, 0, 0)};
    vecs[2]  = '{op(0, 8'd0, 0, 0, 0), op(1, 8'd0, 0, 0, 0), 43'h1};
    vecs[3]  = '{op(0, 8'd0, 0, 1, 0), op(0, 8'd0, 0, 0, 0), 43'h2};
    vecs[4]  = '{op(0, 8'd100, 0, 0, 0), op(0, 8'd0, 0, 0, 0), ex(1, 0, 8'd100, 0, 0, 0)};
    vecs[5]  = '{op(0, 8'd0, 0, 0, 0), op(0, 8'd0, 0, 0, 1), ex(0, 0, 8'd0, 0, 0, 0)};
    vecs[6]  = '{op(0, 8'd0, 0, 0, 1), op(1, 8'hFB, 27'h1234567, 0, 0),
                 ex(0, 1, 8'hFB, {27'h1234567, 4'h0}, 0, 0)};
    vecs[7]  = '{op(0, 8'd3, 0, 0, 1), op(1, 8'd9, 0, 0, 1), 43'h1};
    vecs[8]  = '{op(0, 8'd0, 0, 0, 0), op(1, 8'hFF, 27'h4000000, 0, 0), ex(0, 0, 8'hFE, 0, 0, 0)};
    vecs[9]  = '{op(0, 8'hFF, 0, 0, 0), op(1, 8'd1, 0, 0, 0), ex(0, 1, 8'd0, 31'h40000000, 0, 0)};
    vecs[10] = '{op(0, 8'h80, 27'h4000000, 0, 0), op(1, 8'h80, 0, 0, 0), ex(0, 0, 8'h80, 0, 0, 0)};
    vecs[11] = '{op(0, 8'h7F, 0, 0, 0), op(0, 8'h7F, 0, 0, 0), ex(0, 0, 8'h7F, 0, 0, 0)};
    vecs[12] = '{op(1, 8'd0, 0, 0, 1), op(0, 8'h12, 27'h55, 1, 0), 43'h2};
    vecs[13] = '{op(0, 8'd0, 0, 0, 0), op(0, 8'hE1, 0, 0, 0), ex(0, 0, 8'd0, 31'h1, 0, 0)};
    vecs[14] = '{op(0, 8'd0, 0, 0, 0), op(0, 8'hE0, 0, 0, 0), ex(1, 0, 8'd0, 0, 0, 0)};
    vecs[15] = '{op(0, 8'd0, 0, 0, 0), op(0, 8'hFB, 27'h1, 0, 0), ex(1, 0, 8'd0, 31'h04000000, 0, 0)};

    reset = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_truncated", 64'(truncated), 64'd0);
    reset = 1'b0;

    // Directed vectors back to back, then idle cycles with live operands.
    for (int i = 0; i < 16; i++) cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
    for (int i = 0; i < 6; i++) cycle(1'b0, rnd_op(), rnd_op(), 43'h0);

    // Continuous stream with start held high.
    for (int i = 0; i < 150; i++) begin
      a = rnd_op();
      b = rnd_near(a);
      cycle(1'b1, a, b, model(a, b));
    end

    // Reset in the middle of a stream: outputs clear at once, in-flight work is dropped.
    @(negedge clk);
    check_out();
    #2 reset = 1'b1;
    #1;
    chk("midreset_result", 64'(result), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_truncated", 64'(truncated), 64'd0);
    sb.delete();
    hist.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, rnd_op(), rnd_op(), 43'h0);

    // Random start pattern.
    for (int i = 0; i < 60; i++) begin
      a = rnd_op();
      b = rnd_near(a);
      cycle(1'($urandom_range(0, 1)), a, b, model(a, b));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 43'h0);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
